// File: rtl/dp_sink_lt_responder.sv
// Sink-side link-training responder: latches source drive settings, models receiver lock time, publishes CR/EQ status.
// Latency: status updates N edges after the loading edge (N = CR_LOCK_CYC or the EQ lock delay chosen by rd_interval).
// Backpressure: none; strobes are always accepted, and a new setting restarts the lock timer of the current phase.
module dp_sink_lt_responder #(
    parameter int CR_LOCK_CYC = 5,
    parameter int CNT_W       = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] lane_count,
    input  logic [7:0] rd_interval,
    input  logic       tps_vld,
    input  logic [1:0] tps,
    input  logic       lane_set_vld,
    input  logic [7:0] lane_vswing,
    input  logic [7:0] lane_preemph,
    input  logic [7:0] tgt_vswing,
    input  logic [7:0] tgt_preemph,
    output logic [3:0] cr_done,
    output logic [3:0] eq_done,
    output logic [3:0] symbol_locked,
    output logic       interlane_align,
    output logic [7:0] adj_vswing,
    output logic [7:0] adj_preemph,
    output logic       status_busy,
    output logic       status_vld
);

    typedef enum logic [2:0] {IDLE, CR_WAIT, CR_HOLD, EQ_WAIT, EQ_HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] eq_lock_q, eq_lock_d;
    logic [7:0]       vswing_q, vswing_d;
    logic [7:0]       preemph_q, preemph_d;
    logic [3:0]       cr_done_q, cr_done_d;
    logic [3:0]       eq_done_q, eq_done_d;
    logic [3:0]       sym_lock_q, sym_lock_d;
    logic             align_q, align_d;
    logic [7:0]       adj_vs_q, adj_vs_d;
    logic [7:0]       adj_pe_q, adj_pe_d;
    logic             busy_q, busy_d;
    logic             vld_q, vld_d;

    logic [3:0]       lane_mask;
    logic [7:0]       field_mask;
    logic [CNT_W-1:0] eq_lock_sel;
    logic [3:0]       cr_ok;
    logic [3:0]       eq_ok;
    logic [2:0]       lvl_sum;

    // Active-lane mask, EQ lock delay decode and per-lane pass checks on the latched settings
    always_comb begin
        case (lane_count)
            3'd1:    lane_mask = 4'b0001;
            3'd2:    lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
        field_mask = {{2{lane_mask[3]}}, {2{lane_mask[2]}}, {2{lane_mask[1]}}, {2{lane_mask[0]}}};
        case (rd_interval)
            8'h00:   eq_lock_sel = CNT_W'(20);
            8'h01:   eq_lock_sel = CNT_W'(200);
            8'h02:   eq_lock_sel = CNT_W'(400);
            8'h03:   eq_lock_sel = CNT_W'(600);
            default: eq_lock_sel = CNT_W'(800);
        endcase
        cr_ok   = 4'b0000;
        eq_ok   = 4'b0000;
        lvl_sum = 3'd0;
        for (int i = 0; i < 4; i++) begin
            // Swing 3 is the maximum level, so the receiver cannot ask for more
            cr_ok[i] = (vswing_q[2*i +: 2] == tgt_vswing[2*i +: 2]) || (vswing_q[2*i +: 2] == 2'b11);
            // Swing + pre-emphasis at 3 is the maximum combined drive level
            lvl_sum  = {1'b0, vswing_q[2*i +: 2]} + {1'b0, preemph_q[2*i +: 2]};
            eq_ok[i] = (preemph_q[2*i +: 2] == tgt_preemph[2*i +: 2]) || (lvl_sum == 3'd3);
        end
    end

    // Next-state logic: a training-pattern write wins over a lane-setting write, which wins over the timer
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        eq_lock_d  = eq_lock_q;
        vswing_d   = vswing_q;
        preemph_d  = preemph_q;
        cr_done_d  = cr_done_q;
        eq_done_d  = eq_done_q;
        sym_lock_d = sym_lock_q;
        align_d    = align_q;
        adj_vs_d   = adj_vs_q;
        adj_pe_d   = adj_pe_q;
        vld_d      = 1'b0;

        if (lane_set_vld) begin
            vswing_d  = lane_vswing;
            preemph_d = lane_preemph;
        end

        if (tps_vld) begin
            eq_lock_d = eq_lock_sel;
            case (tps)
                2'b01: begin
                    cr_done_d  = 4'b0000;
                    eq_done_d  = 4'b0000;
                    sym_lock_d = 4'b0000;
                    align_d    = 1'b0;
                    timer_d    = CNT_W'(CR_LOCK_CYC);
                    state_d    = CR_WAIT;
                end
                2'b10, 2'b11: begin
                    eq_done_d  = 4'b0000;
                    sym_lock_d = 4'b0000;
                    align_d    = 1'b0;
                    if ((cr_done_q & lane_mask) == lane_mask) begin
                        timer_d = eq_lock_sel;
                        state_d = EQ_WAIT;
                    end else begin
                        timer_d = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    timer_d = '0;
                    state_d = IDLE;
                end
            endcase
        end else if (lane_set_vld && (state_q == CR_WAIT || state_q == CR_HOLD)) begin
            timer_d = CNT_W'(CR_LOCK_CYC);
            state_d = CR_WAIT;
        end else if (lane_set_vld && (state_q == EQ_WAIT || state_q == EQ_HOLD)) begin
            timer_d = eq_lock_q;
            state_d = EQ_WAIT;
        end else if (state_q == CR_WAIT || state_q == EQ_WAIT) begin
            if (timer_q > CNT_W'(1)) begin
                timer_d = timer_q - CNT_W'(1);
            end else begin
                // Last lock cycle: publish status on this edge
                timer_d  = '0;
                vld_d    = 1'b1;
                adj_vs_d = tgt_vswing & field_mask;
                adj_pe_d = tgt_preemph & field_mask;
                cr_done_d = cr_ok & lane_mask;
                if (state_q == CR_WAIT) begin
                    eq_done_d  = eq_done_q & lane_mask;
                    sym_lock_d = sym_lock_q & lane_mask;
                    state_d    = CR_HOLD;
                end else begin
                    eq_done_d  = cr_ok & eq_ok & lane_mask;
                    sym_lock_d = cr_ok & eq_ok & lane_mask;
                    align_d    = ((cr_ok & eq_ok & lane_mask) == lane_mask);
                    state_d    = ((cr_ok & lane_mask) == lane_mask) ? EQ_HOLD : IDLE;
                end
            end
        end

        busy_d = (state_d == CR_WAIT) || (state_d == EQ_WAIT);
    end

    // State, settings and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            eq_lock_q  <= '0;
            vswing_q   <= '0;
            preemph_q  <= '0;
            cr_done_q  <= '0;
            eq_done_q  <= '0;
            sym_lock_q <= '0;
            align_q    <= 1'b0;
            adj_vs_q   <= '0;
            adj_pe_q   <= '0;
            busy_q     <= 1'b0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            eq_lock_q  <= eq_lock_d;
            vswing_q   <= vswing_d;
            preemph_q  <= preemph_d;
            cr_done_q  <= cr_done_d;
            eq_done_q  <= eq_done_d;
            sym_lock_q <= sym_lock_d;
            align_q    <= align_d;
            adj_vs_q   <= adj_vs_d;
            adj_pe_q   <= adj_pe_d;
            busy_q     <= busy_d;
            vld_q      <= vld_d;
        end
    end

    assign cr_done         = cr_done_q;
    assign eq_done         = eq_done_q;
    assign symbol_locked   = sym_lock_q;
    assign interlane_align = align_q;
    assign adj_vswing      = adj_vs_q;
    assign adj_preemph     = adj_pe_q;
    assign status_busy     = busy_q;
    assign status_vld      = vld_q;

endmodule

// File: tb/tb_dp_sink_lt_responder.sv
// Directed bench for the link-training responder: CR/EQ lock timing, adjust loop, lane masking, reset.
// Latency: checks status_vld lands exactly N edges after the loading edge.
// Backpressure: none; strobes are single-cycle and driven #1 after the rising edge.
module tb_dp_sink_lt_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] lane_count = 3'd4;
    logic [7:0] rd_interval = 8'h00;
    logic       tps_vld = 1'b0;
    logic [1:0] tps = 2'b00;
    logic       lane_set_vld = 1'b0;
    logic [7:0] lane_vswing = 8'h00;
    logic [7:0] lane_preemph = 8'h00;
    logic [7:0] tgt_vswing = 8'h00;
    logic [7:0] tgt_preemph = 8'h00;
    logic [3:0] cr_done;
    logic [3:0] eq_done;
    logic [3:0] symbol_locked;
    logic       interlane_align;
    logic [7:0] adj_vswing;
    logic [7:0] adj_preemph;
    logic       status_busy;
    logic       status_vld;

    int checks = 0;
    int failures = 0;
    int n_edges;
    int busy_cnt;
    int pulses;

    dp_sink_lt_responder #(.CR_LOCK_CYC(5), .CNT_W(10)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lane_count      (lane_count),
        .rd_interval     (rd_interval),
        .tps_vld         (tps_vld),
        .tps             (tps),
        .lane_set_vld    (lane_set_vld),
        .lane_vswing     (lane_vswing),
        .lane_preemph    (lane_preemph),
        .tgt_vswing      (tgt_vswing),
        .tgt_preemph     (tgt_preemph),
        .cr_done         (cr_done),
        .eq_done         (eq_done),
        .symbol_locked   (symbol_locked),
        .interlane_align (interlane_align),
        .adj_vswing      (adj_vswing),
        .adj_preemph     (adj_preemph),
        .status_busy     (status_busy),
        .status_vld      (status_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_lane(input logic [7:0] vs, input logic [7:0] pe);
        lane_vswing  = vs;
        lane_preemph = pe;
        lane_set_vld = 1'b1;
        step();
        lane_set_vld = 1'b0;
    endtask

    task automatic wr_tps(input logic [1:0] t);
        tps     = t;
        tps_vld = 1'b1;
        step();
        tps_vld = 1'b0;
    endtask

    // Counts edges until status_vld is seen (bounded), and cycles sampled with status_busy high
    task automatic run_to_vld(input int max, output int n, output int bc);
        n  = 0;
        bc = 0;
        while (n < max) begin
            if (status_busy) bc++;
            step();
            n++;
            if (status_vld) break;
        end
    endtask

    task automatic quiet(input int cyc, output int p);
        p = 0;
        for (int i = 0; i < cyc; i++) begin
            step();
            if (status_vld) p++;
        end
    endtask

    initial begin
        // Reset values
        step();
        step();
        chk("rst_cr", cr_done, 4'h0);
        chk("rst_eq", eq_done, 4'h0);
        chk("rst_sym", symbol_locked, 4'h0);
        chk("rst_align", interlane_align, 1'b0);
        chk("rst_adjvs", adj_vswing, 8'h00);
        chk("rst_adjpe", adj_preemph, 8'h00);
        chk("rst_busy", status_busy, 1'b0);
        chk("rst_vld", status_vld, 1'b0);
        rst_n = 1'b1;
        step();

        // CR pass on 4 lanes
        lane_count = 3'd4;
        tgt_vswing = 8'h55;
        tgt_preemph = 8'h00;
        wr_lane(8'h55, 8'h00);
        chk("idle_latch_busy", status_busy, 1'b0);
        wr_tps(2'b01);
        run_to_vld(50, n_edges, busy_cnt);
        chk("cr_pass_edges", n_edges, 5);
        chk("cr_pass_busy", busy_cnt, 5);
        chk("cr_pass_cr", cr_done, 4'hF);
        chk("cr_pass_adjvs", adj_vswing, 8'h55);
        chk("cr_pass_busy_after", status_busy, 1'b0);
        step();
        chk("cr_pass_vld_pulse", status_vld, 1'b0);

        // CR adjust loop from CR_HOLD
        wr_lane(8'h00, 8'h00);
        run_to_vld(50, n_edges, busy_cnt);
        chk("cr_adj_edges1", n_edges, 5);
        chk("cr_adj_cr0", cr_done, 4'h0);
        chk("cr_adj_adjvs", adj_vswing, 8'h55);
        wr_lane(8'h55, 8'h00);
        run_to_vld(50, n_edges, busy_cnt);
        chk("cr_adj_edges2", n_edges, 5);
        chk("cr_adj_crF", cr_done, 4'hF);

        // EQ lock intervals
        tgt_preemph = 8'hAA;
        wr_lane(8'h55, 8'hAA);
        run_to_vld(50, n_edges, busy_cnt);
        chk("eq_pre_cr", cr_done, 4'hF);
        rd_interval = 8'h01;
        wr_tps(2'b10);
        run_to_vld(1000, n_edges, busy_cnt);
        chk("eq200_edges", n_edges, 200);
        chk("eq200_eq", eq_done, 4'hF);
        chk("eq200_sym", symbol_locked, 4'hF);
        chk("eq200_align", interlane_align, 1'b1);
        chk("eq200_adjpe", adj_preemph, 8'hAA);
        rd_interval = 8'h07;
        wr_tps(2'b11);
        chk("eq800_cleared", eq_done, 4'h0);
        run_to_vld(1000, n_edges, busy_cnt);
        chk("eq800_edges", n_edges, 800);
        chk("eq800_align", interlane_align, 1'b1);

        // EQ before CR completes
        wr_tps(2'b01);
        wr_lane(8'h00, 8'hAA);
        run_to_vld(50, n_edges, busy_cnt);
        chk("nocr_cr", cr_done, 4'h0);
        rd_interval = 8'h00;
        wr_tps(2'b10);
        quiet(30, pulses);
        chk("nocr_pulses", pulses, 0);
        chk("nocr_busy", status_busy, 1'b0);
        chk("nocr_eq", eq_done, 4'h0);
        wr_lane(8'h55, 8'hAA);
        quiet(10, pulses);
        chk("idle_lane_pulses", pulses, 0);

        // CR loss on lane 1 during EQ
        wr_tps(2'b01);
        run_to_vld(50, n_edges, busy_cnt);
        chk("loss_cr_pre", cr_done, 4'hF);
        wr_tps(2'b10);
        step();
        step();
        chk("loss_busy", status_busy, 1'b1);
        wr_lane(8'h51, 8'hAA);
        run_to_vld(100, n_edges, busy_cnt);
        chk("loss_edges", n_edges, 20);
        chk("loss_cr", cr_done, 4'hD);
        chk("loss_eq", eq_done, 4'hD);
        chk("loss_align", interlane_align, 1'b0);
        wr_lane(8'h55, 8'hAA);
        quiet(10, pulses);
        chk("loss_idle_pulses", pulses, 0);
        chk("loss_idle_busy", status_busy, 1'b0);

        // Two lanes, max swing, and max combined level on lane 0
        lane_count = 3'd2;
        wr_tps(2'b01);
        wr_lane(8'hFF, 8'h00);
        run_to_vld(50, n_edges, busy_cnt);
        chk("l2_cr", cr_done, 4'h3);
        chk("l2_adjvs", adj_vswing, 8'h05);
        chk("l2_adjpe", adj_preemph, 8'h0A);
        tgt_vswing = 8'h56;
        wr_lane(8'hFE, 8'h05);
        run_to_vld(50, n_edges, busy_cnt);
        chk("l2_cr2", cr_done, 4'h3);
        chk("l2_adjvs2", adj_vswing, 8'h06);
        wr_tps(2'b10);
        run_to_vld(100, n_edges, busy_cnt);
        chk("l2_eq_edges", n_edges, 20);
        chk("l2_eq", eq_done, 4'h1);
        chk("l2_sym", symbol_locked, 4'h1);
        chk("l2_align", interlane_align, 1'b0);
        chk("l2_eq_cr", cr_done, 4'h3);

        // Simultaneous strobes: both latch, CR pattern governs
        lane_count = 3'd4;
        tgt_vswing = 8'h55;
        tps = 2'b01;
        tps_vld = 1'b1;
        lane_vswing = 8'h55;
        lane_preemph = 8'hAA;
        lane_set_vld = 1'b1;
        step();
        tps_vld = 1'b0;
        lane_set_vld = 1'b0;
        chk("sim_busy", status_busy, 1'b1);
        run_to_vld(50, n_edges, busy_cnt);
        chk("sim_edges", n_edges, 5);
        chk("sim_cr", cr_done, 4'hF);

        // Reset during EQ_WAIT
        wr_tps(2'b10);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mrst_cr", cr_done, 4'h0);
        chk("mrst_adjvs", adj_vswing, 8'h00);
        chk("mrst_busy", status_busy, 1'b0);
        quiet(5, pulses);
        rst_n = 1'b1;
        begin
            int p2;
            quiet(25, p2);
            pulses += p2;
        end
        chk("mrst_pulses", pulses, 0);
        chk("mrst_busy_after", status_busy, 1'b0);
        chk("mrst_eq", eq_done, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dp_sink_lt_responder.md
Name: dp_sink_lt_responder

Overview:
- Sink-side link-training responder: the peer of the source's CR/EQ wait counter.
- Accepts training-pattern and per-lane drive settings written by the source, models receiver lock time, then publishes CR_DONE / CHANNEL_EQ_DONE / SYMBOL_LOCKED / INTERLANE_ALIGN and ADJUST_REQUEST values.
- Status is guaranteed valid before the source's wait window expires.
- Sits behind the sink DPCD register file, which drives the *_vld strobes and reads the status outputs.

Parameters:
- CR_LOCK_CYC, 5, CR lock delay in clk cycles. Must be < 10, the source CR wait.
- CNT_W, 10, lock-timer width. Must hold 800.

Ports:
- clk  in  1  100 kHz clock
- rst_n  in  1  asynchronous, active-low reset
- lane_count  in  3  active lanes: 1, 2 or 4; any other value treated as 4
- rd_interval  in  8  TRAINING_AUX_RD_INTERVAL code advertised to source
- tps_vld  in  1  one-cycle strobe: tps written
- tps  in  2  00 none, 01 TPS1 (CR), 10/11 TPS2/3/4 (EQ)
- lane_set_vld  in  1  one-cycle strobe: lane_vswing/lane_preemph written
- lane_vswing  in  8  2 bits per lane, lane0 = [1:0]
- lane_preemph  in  8  2 bits per lane
- tgt_vswing  in  8  receiver-preferred swing per lane
- tgt_preemph  in  8  receiver-preferred pre-emphasis per lane
- cr_done  out  4  per-lane CR_DONE
- eq_done  out  4  per-lane CHANNEL_EQ_DONE
- symbol_locked  out  4  per-lane SYMBOL_LOCKED
- interlane_align  out  1  INTERLANE_ALIGN_DONE
- adj_vswing  out  8  ADJUST_REQUEST swing per lane
- adj_preemph  out  8  ADJUST_REQUEST pre-emphasis per lane
- status_busy  out  1  high while lock timer runs; status not yet updated
- status_vld  out  1  one-cycle pulse when status outputs update

Behaviour:
- **Reset:** all outputs 0; state IDLE; timer 0; latched settings 0.
- **Latching:** tps_vld and lane_set_vld latch their data on the sampling edge. Both strobes in the same cycle: both latch, and the tps transition governs the next state.
- **EQ lock delay** EQ_LOCK from rd_interval, taken at tps_vld: 00→20, 01→200, 02→400, 03→600, else 800. This is half the source's EQ wait.
- **States:** IDLE, CR_WAIT, CR_HOLD, EQ_WAIT, EQ_HOLD. status_busy = 1 in CR_WAIT and EQ_WAIT only.
- **tps_vld, tps=01 (any state):**
  - clear cr_done, eq_done, symbol_locked, interlane_align;
  - timer ← CR_LOCK_CYC; go to CR_WAIT.
- **tps_vld, tps=10/11:**
  - if all active cr_done = 1: clear eq_done, symbol_locked, interlane_align; timer ← EQ_LOCK; go to EQ_WAIT;
  - else: go to IDLE with eq bits 0.
- **tps_vld, tps=00:** go to IDLE. Status outputs hold their last values.
- **lane_set_vld without tps_vld:**
  - in CR_WAIT or CR_HOLD: timer ← CR_LOCK_CYC, go to CR_WAIT;
  - in EQ_WAIT or EQ_HOLD: timer ← EQ_LOCK, go to EQ_WAIT;
  - in IDLE: latch only.
- **Timer:**
  - decrements by 1 per cycle in WAIT states;
  - the status update and the status_vld pulse occur on the N-th rising edge after the loading edge (N = loaded value);
  - the timer does not decrement below 0.
- **CR evaluation, lane i active:**
  - cr_done[i] = (vswing[i] == tgt_vswing[i]) OR (vswing[i] == 2'b11);
  - adj_* ← tgt_*;
  - go to CR_HOLD.
- **EQ evaluation, lane i active:**
  - CR re-checked first, using the CR rule; a failing lane clears cr_done[i];
  - eq_done[i] = cr_done[i] AND ((preemph[i] == tgt_preemph[i]) OR (vswing[i] + preemph[i] == 3));
  - symbol_locked = eq_done;
  - interlane_align = AND of eq_done over active lanes;
  - adj_* ← tgt_*;
  - go to EQ_HOLD.
  - If any active lane lost CR: go to IDLE instead of EQ_HOLD, status_vld still pulses.
- **Inactive lanes:** all status bits 0 and adj fields 0 at every evaluation.
- **Addition width:** 3-bit, no overflow.
- **Reset mid-operation:** immediate return to reset values; no status_vld pulse.

Test Plan:
- **CR pass:** lane_count=4, tgt_vswing=8'h55, lane_set_vld with vswing=8'h55, then tps_vld tps=01 → status_busy for 5 cycles, status_vld on 5th edge, cr_done=4'hF, adj_vswing=8'h55.
- **CR adjust loop:** vswing=8'h00, tgt=8'h55 → cr_done=0. lane_set_vld with vswing=8'h55 in CR_HOLD → timer restarts, cr_done=4'hF 5 cycles later.
- **EQ interval:** rd_interval=01, CR done, tps=10, preemph matches tgt → status_vld exactly 200 cycles later, eq_done=symbol_locked=4'hF, interlane_align=1. Repeat with rd_interval=8'h07 → 800 cycles.
- **EQ before CR / CR loss:** tps=10 with cr_done=0 → IDLE, no pulse. Lane1 vswing changed to a non-target value during EQ → cr_done=4'hD, interlane_align=0, state IDLE.
- **Lane count and max:** lane_count=2, vswing=8'hFF → cr_done=4'h3, adj fields for lanes 2–3 = 0. vswing=2, preemph=1 on lane0 → eq_done[0]=1 despite tgt mismatch.
- **Simultaneous / reset:** tps_vld (01) and lane_set_vld in the same cycle → both latched, CR_WAIT. rst_n low at cycle 3 of EQ_WAIT → all outputs 0, no status_vld.
